tcp_rx_ctrl: RTL and testbench
==============================

Name: tcp_rx_ctrl

Overview:
Control FSM for the TCP receive datapath. It sequences each inbound header through these steps:
- flow-CAM lookup;
- flow-state read;
- ack/window calculation;
- state write-back and scheduler update;
- hand-off of the payload entry to the RX destination.
SYN packets that miss in the CAM take the slow path: flowid allocation, new-flow table writes, app notification and SYN-ACK enqueue. The block drives the datapath's save/store strobes and all memory request valids; it holds no packet data itself.

Parameters:
RD_LATENCY, 2, cycles from flow_state_rd_req_val to valid read data on all four flow-state memories (≥1)
CNT_W, 16, width of the drop counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
src_tcp_rx_hdr_val  in  1  inbound header valid
tcp_rx_src_hdr_rdy  out  1  inbound header ready
src_syn_flag  in  1  SYN flag of the inbound header (same cycle as val)
ctrl_datap_save_input  out  1  datapath latches ip/hdr/payload entry
read_flow_cam_val  out  1  CAM lookup strobe
read_flow_cam_hit  in  1  CAM hit, combinational, same cycle as strobe
store_flowid_cam  out  1  datapath latches CAM flowid
flowid_manager_req  out  1  request a free flowid
flowid_manager_avail  in  1  flowid granted, same cycle as req
store_flowid_manager  out  1  datapath latches manager flowid
flow_state_rd_req_val  out  1  read rx/tx state, rx head/tail ptrs
ctrl_datap_save_flow_state  out  1  datapath latches read data
ctrl_datap_save_calcs  out  1  datapath latches calc results
next_rx_state_wr_req_val  out  1  rx state write
rx_tail_ptr_wr_req_val  out  1  rx tail ptr write
tx_head_ptr_wr_req_val  out  1  tx head ptr write
rx_sched_update_val  out  1  scheduler command valid
tcp_rx_dst_hdr_val  out  1  payload entry to destination, valid
dst_tcp_rx_hdr_rdy  in  1  destination ready
new_flow_val / new_flow_rdy  out/in  1  new-flow table writes
app_new_flow_notif_val / app_new_flow_notif_rdy  out/in  1  app notification
slow_path_send_pkt_enqueue_val / _rdy  out/in  1  SYN-ACK enqueue
pkt_drop_cnt  out  CNT_W  dropped-packet counter

Behaviour:
Reset and output timing:
- While rst is high: state=IDLE, all outputs 0 (tcp_rx_src_hdr_rdy gated by rst), done bits and counters cleared.
- rst asserted mid-operation aborts the packet; no further strobes or writes are issued for it.
- All outputs are Moore-decoded from state, except the IDLE and FLOWID_REQ strobes, which are combinational on inputs as listed below.

States:
- IDLE: rdy=1. On val:
  - assert save_input, read_flow_cam_val and store_flowid_cam in the same cycle. The CAM tag is driven from unregistered inputs, so the lookup must happen in the accept cycle.
  - hit & !syn → RD_REQ.
  - !hit & syn → FLOWID_REQ.
  - otherwise (non-SYN miss, or duplicate SYN hit) → IDLE and increment pkt_drop_cnt.
- RD_REQ: flow_state_rd_req_val=1 for one cycle; load wait counter = RD_LATENCY; → RD_WAIT.
- RD_WAIT: decrement counter. When it reaches the cycle exactly RD_LATENCY after the request, assert ctrl_datap_save_flow_state and → CALC.
- CALC: ctrl_datap_save_calcs=1 for one cycle → WRITE.
- WRITE: the three write valids and rx_sched_update_val are all 1 for exactly one cycle. Writes are unconditional: the datapath supplies an unchanged tail when the payload is rejected. → DST.
- DST: tcp_rx_dst_hdr_val=1 until the cycle dst_tcp_rx_hdr_rdy=1, then → IDLE.
- FLOWID_REQ: flowid_manager_req=1.
  - avail=1: store_flowid_manager=1 → NEW_FLOW.
  - avail=0: increment drop count → IDLE.
- NEW_FLOW: the three valids are raised together.
  - Each valid holds until its own rdy. The handshake completes in the cycle val&rdy, the done bit sets, and val drops the next cycle.
  - When all three done bits are set (including simultaneous completion), clear them → IDLE.

Counter and throughput:
- pkt_drop_cnt saturates at all-ones and never wraps.
- Exactly one packet is in flight; no new header is accepted outside IDLE.

Test Plan:
- RD_LATENCY=2, hit non-SYN accepted at cycle 0 → rd_req cycle 1, save_flow_state cycle 3, save_calcs cycle 4, three writes + sched_update cycle 5 only, dst_val from cycle 6; dst_rdy held low 3 cycles → val held until the cycle rdy=1, rdy back in IDLE the next cycle.
- Miss SYN, avail=1, new_flow_rdy at +1, notif_rdy at +4, enqueue_rdy at +2 → each val drops after its handshake; return to IDLE the cycle after the +4 handshake; no memory write valids asserted.
- Miss non-SYN, hit SYN, and miss SYN with avail=0 (3 packets) → pkt_drop_cnt=3, no rd_req, no writes.
- CNT_W=2, 5 drops → pkt_drop_cnt stays 3.
- rst pulsed during RD_WAIT and during NEW_FLOW with one done bit set → all outputs 0 immediately, IDLE after release, next SYN requires all three handshakes again.
- Back-to-back valid headers → second accepted only when the FSM is back in IDLE; no strobe overlap.

Source files
------------

// File: rtl/tcp_rx_ctrl.sv
// rtl/tcp_rx_ctrl.sv - control FSM for the TCP receive datapath
//
// Purpose: sequences each accepted header through CAM lookup, flow-state read,
// ack/window calc, state write-back plus scheduler update, and destination
// hand-off. SYN misses take the slow path instead: flowid allocation, then the
// new-flow table write, app notification and SYN-ACK enqueue as three
// independent handshakes. No packet data is held here; only strobes and
// request valids.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   src_tcp_rx_hdr_val/_rdy, src_syn_flag      inbound header handshake
//   ctrl_datap_save_input, read_flow_cam_val,
//   store_flowid_cam, read_flow_cam_hit        accept-cycle lookup strobes
//   flowid_manager_req/_avail, store_flowid_manager   flowid allocation
//   flow_state_rd_req_val, ctrl_datap_save_flow_state  flow-state read
//   ctrl_datap_save_calcs                      calc results latch
//   next_rx_state_wr_req_val, rx_tail_ptr_wr_req_val,
//   tx_head_ptr_wr_req_val, rx_sched_update_val  write-back strobes
//   tcp_rx_dst_hdr_val / dst_tcp_rx_hdr_rdy    destination handshake
//   new_flow_*, app_new_flow_notif_*,
//   slow_path_send_pkt_enqueue_*               slow-path handshakes
//   pkt_drop_cnt                               saturating drop counter
module tcp_rx_ctrl #(
  parameter int RD_LATENCY = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_tcp_rx_hdr_val,
  output logic             tcp_rx_src_hdr_rdy,
  input  logic             src_syn_flag,
  output logic             ctrl_datap_save_input,
  output logic             read_flow_cam_val,
  input  logic             read_flow_cam_hit,
  output logic             store_flowid_cam,
  output logic             flowid_manager_req,
  input  logic             flowid_manager_avail,
  output logic             store_flowid_manager,
  output logic             flow_state_rd_req_val,
  output logic             ctrl_datap_save_flow_state,
  output logic             ctrl_datap_save_calcs,
  output logic             next_rx_state_wr_req_val,
  output logic             rx_tail_ptr_wr_req_val,
  output logic             tx_head_ptr_wr_req_val,
  output logic             rx_sched_update_val,
  output logic             tcp_rx_dst_hdr_val,
  input  logic             dst_tcp_rx_hdr_rdy,
  output logic             new_flow_val,
  input  logic             new_flow_rdy,
  output logic             app_new_flow_notif_val,
  input  logic             app_new_flow_notif_rdy,
  output logic             slow_path_send_pkt_enqueue_val,
  input  logic             slow_path_send_pkt_enqueue_rdy,
  output logic [CNT_W-1:0] pkt_drop_cnt
);

  localparam int WAIT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CALC,
    WRITE,
    DST,
    FLOWID_REQ,
    NEW_FLOW
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              nf_done;
  logic              notif_done;
  logic              enq_done;
  logic [CNT_W-1:0]  drop_cnt;

  logic accept;
  logic nf_hs;
  logic notif_hs;
  logic enq_hs;
  logic all_done;
  logic wait_last;

  // Lookup strobes fire in the accept cycle because the CAM tag comes
  // straight from the unregistered header inputs.
  assign accept = (state == IDLE) && src_tcp_rx_hdr_val && !rst;

  assign tcp_rx_src_hdr_rdy    = (state == IDLE) && !rst;
  assign ctrl_datap_save_input = accept;
  assign read_flow_cam_val     = accept;
  assign store_flowid_cam      = accept;

  assign flowid_manager_req   = (state == FLOWID_REQ);
  assign store_flowid_manager = (state == FLOWID_REQ) && flowid_manager_avail;

  // wait_cnt is loaded with RD_LATENCY in RD_REQ, so the count of 1 lands
  // exactly RD_LATENCY cycles after the read request.
  assign wait_last                  = (wait_cnt == WAIT_W'(1));
  assign flow_state_rd_req_val      = (state == RD_REQ);
  assign ctrl_datap_save_flow_state = (state == RD_WAIT) && wait_last;
  assign ctrl_datap_save_calcs      = (state == CALC);

  assign next_rx_state_wr_req_val = (state == WRITE);
  assign rx_tail_ptr_wr_req_val   = (state == WRITE);
  assign tx_head_ptr_wr_req_val   = (state == WRITE);
  assign rx_sched_update_val      = (state == WRITE);

  assign tcp_rx_dst_hdr_val = (state == DST);

  // Each slow-path valid drops the cycle after its own handshake completes.
  assign new_flow_val                   = (state == NEW_FLOW) && !nf_done;
  assign app_new_flow_notif_val         = (state == NEW_FLOW) && !notif_done;
  assign slow_path_send_pkt_enqueue_val = (state == NEW_FLOW) && !enq_done;

  assign nf_hs    = new_flow_val && new_flow_rdy;
  assign notif_hs = app_new_flow_notif_val && app_new_flow_notif_rdy;
  assign enq_hs   = slow_path_send_pkt_enqueue_val && slow_path_send_pkt_enqueue_rdy;
  // Counts a handshake completing this cycle, so simultaneous finishes exit at once.
  assign all_done = (nf_done || nf_hs) && (notif_done || notif_hs) && (enq_done || enq_hs);

  assign pkt_drop_cnt = drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      nf_done    <= 1'b0;
      notif_done <= 1'b0;
      enq_done   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (src_tcp_rx_hdr_val) begin
            if (read_flow_cam_hit && !src_syn_flag) begin
              state <= RD_REQ;
            end else if (!read_flow_cam_hit && src_syn_flag) begin
              state <= FLOWID_REQ;
            end else if (drop_cnt != {CNT_W{1'b1}}) begin
              drop_cnt <= drop_cnt + 1'b1;
            end
          end
        end
        RD_REQ: begin
          wait_cnt <= WAIT_W'(RD_LATENCY);
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_last) begin
            state <= CALC;
          end
        end
        CALC: begin
          state <= WRITE;
        end
        WRITE: begin
          state <= DST;
        end
        DST: begin
          if (dst_tcp_rx_hdr_rdy) begin
            state <= IDLE;
          end
        end
        FLOWID_REQ: begin
          if (flowid_manager_avail) begin
            state <= NEW_FLOW;
          end else begin
            state <= IDLE;
            if (drop_cnt != {CNT_W{1'b1}}) begin
              drop_cnt <= drop_cnt + 1'b1;
            end
          end
        end
        NEW_FLOW: begin
          if (all_done) begin
            nf_done    <= 1'b0;
            notif_done <= 1'b0;
            enq_done   <= 1'b0;
            state      <= IDLE;
          end else begin
            if (nf_hs) nf_done <= 1'b1;
            if (notif_hs) notif_done <= 1'b1;
            if (enq_hs) enq_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_rx_ctrl.sv
// tb/tb_tcp_rx_ctrl.sv - self-checking bench for tcp_rx_ctrl
module tb_tcp_rx_ctrl;

  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic src_val = 1'b0, syn = 1'b0, hit = 1'b0, avail = 1'b0;
  logic dst_rdy = 1'b0, nf_rdy = 1'b0, notif_rdy = 1'b0, enq_rdy = 1'b0;

  logic rdy, save_in, cam_val, store_cam, mgr_req, store_mgr, rd_req, save_fs, save_calc;
  logic wr_state, wr_tail, wr_head, sched, dst_val, nf_val, notif_val, enq_val;
  logic [15:0] cnt;

  logic x_rdy, x_save_in, x_cam_val, x_store_cam, x_mgr_req, x_store_mgr, x_rd_req, x_save_fs;
  logic x_save_calc, x_wr_state, x_wr_tail, x_wr_head, x_sched, x_dst_val, x_nf_val;
  logic x_notif_val, x_enq_val;
  logic [1:0] cnt2;

  tcp_rx_ctrl #(.RD_LATENCY(L), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .src_tcp_rx_hdr_val(src_val), .tcp_rx_src_hdr_rdy(rdy), .src_syn_flag(syn),
    .ctrl_datap_save_input(save_in), .read_flow_cam_val(cam_val), .read_flow_cam_hit(hit),
    .store_flowid_cam(store_cam), .flowid_manager_req(mgr_req),
    .flowid_manager_avail(avail), .store_flowid_manager(store_mgr),
    .flow_state_rd_req_val(rd_req), .ctrl_datap_save_flow_state(save_fs),
    .ctrl_datap_save_calcs(save_calc), .next_rx_state_wr_req_val(wr_state),
    .rx_tail_ptr_wr_req_val(wr_tail), .tx_head_ptr_wr_req_val(wr_head),
    .rx_sched_update_val(sched), .tcp_rx_dst_hdr_val(dst_val),
    .dst_tcp_rx_hdr_rdy(dst_rdy), .new_flow_val(nf_val), .new_flow_rdy(nf_rdy),
    .app_new_flow_notif_val(notif_val), .app_new_flow_notif_rdy(notif_rdy),
    .slow_path_send_pkt_enqueue_val(enq_val), .slow_path_send_pkt_enqueue_rdy(enq_rdy),
    .pkt_drop_cnt(cnt)
  );

  tcp_rx_ctrl #(.RD_LATENCY(L), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .src_tcp_rx_hdr_val(src_val), .tcp_rx_src_hdr_rdy(x_rdy), .src_syn_flag(syn),
    .ctrl_datap_save_input(x_save_in), .read_flow_cam_val(x_cam_val), .read_flow_cam_hit(hit),
    .store_flowid_cam(x_store_cam), .flowid_manager_req(x_mgr_req),
    .flowid_manager_avail(avail), .store_flowid_manager(x_store_mgr),
    .flow_state_rd_req_val(x_rd_req), .ctrl_datap_save_flow_state(x_save_fs),
    .ctrl_datap_save_calcs(x_save_calc), .next_rx_state_wr_req_val(x_wr_state),
    .rx_tail_ptr_wr_req_val(x_wr_tail), .tx_head_ptr_wr_req_val(x_wr_head),
    .rx_sched_update_val(x_sched), .tcp_rx_dst_hdr_val(x_dst_val),
    .dst_tcp_rx_hdr_rdy(dst_rdy), .new_flow_val(x_nf_val), .new_flow_rdy(nf_rdy),
    .app_new_flow_notif_val(x_notif_val), .app_new_flow_notif_rdy(notif_rdy),
    .slow_path_send_pkt_enqueue_val(x_enq_val), .slow_path_send_pkt_enqueue_rdy(enq_rdy),
    .pkt_drop_cnt(cnt2)
  );

  // Bit order: rdy save_in cam store_cam mgr_req store_mgr rd_req save_fs
  //            calc wr_state wr_tail wr_head sched dst nf notif enq
  wire [16:0] ov = {rdy, save_in, cam_val, store_cam, mgr_req, store_mgr, rd_req, save_fs,
                    save_calc, wr_state, wr_tail, wr_head, sched, dst_val, nf_val,
                    notif_val, enq_val};
  localparam logic [16:0] RDY_ONLY = 17'h10000;

  int checks = 0;
  int errors = 0;
  int drops  = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  task automatic check_cnt(input string tag);
    logic [15:0] e16;
    logic [1:0]  e2;
    e16 = (drops > 65535) ? 16'hffff : 16'(drops);
    e2  = (drops > 3) ? 2'd3 : 2'(drops);
    checks++;
    if (cnt !== e16) begin
      errors++;
      $display("FAIL %s drop_cnt16 got=%0d exp=%0d", tag, cnt, e16);
    end
    checks++;
    if (cnt2 !== e2) begin
      errors++;
      $display("FAIL %s drop_cnt2 got=%0d exp=%0d", tag, cnt2, e2);
    end
  endtask

  task automatic clear_inputs();
    src_val = 0; syn = 0; hit = 0; avail = 0;
    dst_rdy = 0; nf_rdy = 0; notif_rdy = 0; enq_rdy = 0;
  endtask

  // kind: 0 hit non-SYN, 1 miss SYN granted, 2 miss SYN no flowid,
  //       3 miss non-SYN, 4 hit SYN. Called at a negedge with DUT idle.
  // Expected outputs per cycle come from the packet's schedule of events.
  task automatic run_pkt(input int kind, input int dd, input int d0, input int d1,
                         input int d2, input int abort_at);
    int s, e;
    logic [16:0] exp;
    s = 2;
    case (kind)
      0:       e = 5 + L + dd;
      1:       e = s + max3(d0, d1, d2) + 1;
      2:       e = 2;
      default: e = 1;
    endcase
    for (int c = 0; c <= e; c++) begin
      if (c == abort_at) begin
        clear_inputs();
        rst = 1;
        drops = 0;
        #1;
        checks++;
        if (ov !== 17'h0) begin
          errors++;
          $display("FAIL reset_abort outputs got=%b exp=%b", ov, 17'h0);
        end
        check_cnt("reset_abort");
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (ov !== RDY_ONLY) begin
          errors++;
          $display("FAIL after_abort outputs got=%b exp=%b", ov, RDY_ONLY);
        end
        @(negedge clk);
        return;
      end
      src_val   = (c == 0);
      hit       = (c == 0) && (kind == 0 || kind == 4);
      syn       = (c == 0) && (kind == 1 || kind == 2 || kind == 4);
      avail     = (c == 1) && (kind == 1);
      dst_rdy   = (kind == 0) && (c == 4 + L + dd);
      nf_rdy    = (kind == 1) && (c == s + d0);
      notif_rdy = (kind == 1) && (c == s + d1);
      enq_rdy   = (kind == 1) && (c == s + d2);
      #1;
      exp = '0;
      exp[16] = (c == 0) || (c == e);
      exp[15] = (c == 0);
      exp[14] = (c == 0);
      exp[13] = (c == 0);
      if (kind == 0) begin
        exp[10] = (c == 1);
        exp[9]  = (c == 1 + L);
        exp[8]  = (c == 2 + L);
        exp[7]  = (c == 3 + L);
        exp[6]  = (c == 3 + L);
        exp[5]  = (c == 3 + L);
        exp[4]  = (c == 3 + L);
        exp[3]  = (c >= 4 + L) && (c <= 4 + L + dd);
      end else if (kind == 1 || kind == 2) begin
        exp[12] = (c == 1);
        exp[11] = (c == 1) && (kind == 1);
        if (kind == 1) begin
          exp[2] = (c >= s) && (c <= s + d0);
          exp[1] = (c >= s) && (c <= s + d1);
          exp[0] = (c >= s) && (c <= s + d2);
        end
      end
      checks++;
      if (ov !== exp) begin
        errors++;
        $display("FAIL pkt kind=%0d cyc=%0d outputs got=%b exp=%b", kind, c, ov, exp);
      end
      @(negedge clk);
    end
    clear_inputs();
    if (kind >= 2) drops++;
    check_cnt("pkt");
  endtask

  task automatic pulse_reset();
    clear_inputs();
    rst = 1;
    drops = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (ov !== 17'h0) begin
      errors++;
      $display("FAIL reset outputs got=%b exp=%b", ov, 17'h0);
    end
    check_cnt("reset");
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (ov !== RDY_ONLY) begin
      errors++;
      $display("FAIL reset_release outputs got=%b exp=%b", ov, RDY_ONLY);
    end
    @(negedge clk);
  endtask

  task automatic test_fast_path();
    run_pkt(0, 3, 0, 0, 0, -1);
    run_pkt(0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_slow_path();
    run_pkt(1, 0, 1, 4, 2, -1);
    run_pkt(1, 0, 2, 2, 2, -1);
    run_pkt(1, 0, 0, 0, 0, -1);
  endtask

  task automatic test_drops();
    pulse_reset();
    run_pkt(3, 0, 0, 0, 0, -1);
    run_pkt(4, 0, 0, 0, 0, -1);
    run_pkt(2, 0, 0, 0, 0, -1);
    for (int i = 0; i < 5; i++) run_pkt(2 + (i % 3), 0, 0, 0, 0, -1);
  endtask

  task automatic test_reset_midway();
    run_pkt(0, 2, 0, 0, 0, 3);
    run_pkt(1, 0, 0, 4, 4, 4);
    run_pkt(1, 0, 1, 3, 2, -1);
  endtask

  task automatic test_back_to_back();
    int p;
    logic [3:0] got, exp;
    p = L + 5;
    src_val = 1; hit = 1; syn = 0; dst_rdy = 1;
    for (int c = 0; c < 3 * p; c++) begin
      #1;
      got = {rdy, save_in, rd_req, dst_val};
      exp = {(c % p) == 0, (c % p) == 0, (c % p) == 1, (c % p) == 4 + L};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d rdy/save/rd/dst got=%b exp=%b", c, got, exp);
      end
      @(negedge clk);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_random();
    int k, a, b, c, d;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(4);
      a = $urandom_range(3);
      b = $urandom_range(3);
      c = $urandom_range(3);
      d = $urandom_range(3);
      run_pkt(k, a, b, c, d, -1);
    end
  endtask

  initial begin
    test_reset();
    test_fast_path();
    test_slow_path();
    test_drops();
    test_reset_midway();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
